// File: rtl/multi_debouncer.sv
// Per-channel button conditioner: two-flop synchronizer, symmetric counter debounce,
// registered press/release edge pulses and a single long-press pulse per press.
module multi_debouncer #(
  parameter int              N_CH   = 4,
  parameter int              CNT_W  = 16,
  parameter int              HOLD_W = 24,
  parameter logic [N_CH-1:0] INV    = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_long
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_PRE = {{(HOLD_W-1){1'b1}}, 1'b0};
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  logic [N_CH-1:0]   syncMeta_q;
  logic [N_CH-1:0]   sync_q;
  logic [CNT_W-1:0]  cnt_q  [N_CH];
  logic [CNT_W-1:0]  cnt_d  [N_CH];
  logic [HOLD_W-1:0] hold_q [N_CH];
  logic [HOLD_W-1:0] hold_d [N_CH];
  logic [N_CH-1:0]   state_q, state_d;
  logic [N_CH-1:0]   stateDly_q;
  logic [N_CH-1:0]   rise_q, fall_q, long_q, long_d;

  always_comb begin
    state_d = state_q;
    long_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = '0;
      hold_d[i] = hold_q[i];
      if (sync_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          state_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      // Hold counter tracks the registered state, so it starts one edge after the press lands.
      if (!state_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HOLD_MAX) begin
        hold_d[i] = hold_q[i] + HOLD_ONE;
      end
      long_d[i] = state_q[i] && (hold_q[i] == HOLD_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta_q <= '0;
      sync_q     <= '0;
      state_q    <= '0;
      stateDly_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      long_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      syncMeta_q <= btn ^ INV;
      sync_q     <= syncMeta_q;
      state_q    <= state_d;
      stateDly_q <= state_q;
      rise_q     <= state_q & ~stateDly_q;
      fall_q     <= ~state_q & stateDly_q;
      long_q     <= long_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign btn_state = state_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign btn_long  = long_q;

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 16: debounce counter width; debounce window = 2^CNT_W cycles.
REQ-003 The block SHALL have parameter HOLD_W, default 24: long-press counter width; long-press threshold = 2^HOLD_W - 1 cycles of stable press.
REQ-004 The block SHALL have parameter INV, default {N_CH{1'b0}}: per-channel input inversion mask; bit i = 1 means channel i is active-low at the pin.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 btn  input  N_CH  raw asynchronous button inputs.
REQ-008 btn_state  output  N_CH  debounced level per channel, 1 = pressed.
REQ-009 btn_rise  output  N_CH  one-cycle pulse on debounced press.
REQ-010 btn_fall  output  N_CH  one-cycle pulse on debounced release.
REQ-011 btn_long  output  N_CH  one-cycle pulse when a press has been held for the long-press threshold.

Function
REQ-012 Each channel SHALL pass btn[i] XOR INV[i] through a two-flop synchronizer; only the second flop output (sync[i]) feeds debounce logic.
REQ-013 Each channel SHALL have a CNT_W-bit counter cnt[i]: cleared when sync[i] == btn_state[i], incremented when they differ.
REQ-014 When sync[i] != btn_state[i] and cnt[i] == 2^CNT_W-1, btn_state[i] SHALL take sync[i] and cnt[i] SHALL clear on the same edge.
REQ-015 Debouncing SHALL be symmetric: press and release both require 2^CNT_W consecutive differing cycles (unlike release-immediate behaviour).
REQ-016 Any cycle with sync[i] == btn_state[i] inside the window (bounce) SHALL clear cnt[i], restarting the window.
REQ-017 Latency SHALL be exactly 2^CNT_W + 2 rising edges from the first edge that samples a changed, then stable, raw level to the edge updating btn_state[i].
REQ-018 btn_rise[i] / btn_fall[i] SHALL be registered and assert in the cycle immediately after btn_state[i] goes 0->1 / 1->0, for exactly one cycle.
REQ-019 Each channel SHALL have a HOLD_W-bit counter hold[i]: cleared while btn_state[i] == 0, incremented while 1, saturating at 2^HOLD_W-1.
REQ-020 btn_long[i] SHALL pulse for one cycle on the edge where hold[i] transitions to 2^HOLD_W-1; at most once per press, never after saturation.
REQ-021 A release before saturation SHALL clear hold[i] with no btn_long pulse; the next press starts counting from 0.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses with no arbitration or loss.
REQ-023 Counters SHALL never wrap: cnt[i] clears at MAX per REQ-014, hold[i] saturates per REQ-019.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from btn to any output.

Reset
REQ-025 While rst_n = 0, all synchronizer flops, cnt, hold, btn_state, btn_rise, btn_fall and btn_long SHALL be 0, regardless of clk.
REQ-026 Synchronizer flops SHALL reset to 0 (not INV), so an active-low channel idle-high at the pin reads released from the first cycle after reset.
REQ-027 Reset asserted mid-window or mid-hold SHALL abort the operation with no pulses; after rst_n deasserts, a held input SHALL take a full REQ-017 latency to register.
REQ-028 rst_n deassertion SHALL be synchronized externally; the block needs no internal reset synchronizer.

Verification (CNT_W=4, HOLD_W=6, N_CH=4, INV=4'b1000)
REQ-029 btn[0] 0->1 held stable -> btn_state[0]=1 on edge 18 after first sampled edge, btn_rise[0]=1 for exactly one cycle after that.
REQ-030 btn[1] toggles every 5 cycles for 100 cycles, then held 1 -> no btn_state[1] change during toggling; press registers 18 edges after final stable level.
REQ-031 btn[2] pressed and held 100 cycles -> btn_long[2] one pulse 63 cycles after btn_state[2] rises; release -> btn_fall[2] one pulse, no further btn_long.
REQ-032 btn[3] held 1 (idle, INV=1) from reset -> btn_state[3] stays 0; drive 0 -> btn_state[3]=1 after 18 edges.
REQ-033 rst_n pulsed low at cycle 10 of a press window -> all outputs 0 immediately, no pulses; press still held -> btn_state rises 18 edges after rst_n release.
REQ-034 btn[0] and btn[1] pressed on the same edge -> btn_rise = 4'b0011 in a single cycle.
